// File: rtl/stoch_pkg.sv
// stoch_pkg: shared FSM encoding, mode constants and the saturating step used by every channel.
package stoch_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  localparam int MODE_UNIPOLAR = 0;
  localparam int MODE_BIPOLAR = 1;
  localparam int ACC_W = 32;
  typedef struct packed {
    logic sat;
    logic [ACC_W-1:0] val;
  } sat_res_t;
  // acc holds an n-bit pattern zero-extended; bipolar values are n-bit two's complement.
  function automatic sat_res_t sat_add(input logic [ACC_W-1:0] acc, input logic b,
                                       input logic bipolar, input int n);
    logic [ACC_W-1:0] mask, hi, lo;
    sat_res_t r;
    mask = (ACC_W'(1) << n) - ACC_W'(1);
    hi = bipolar ? (ACC_W'(1) << (n - 1)) - ACC_W'(1) : mask;
    lo = bipolar ? ACC_W'(1) << (n - 1) : '0;
    r.sat = b ? (acc == hi) : (bipolar && acc == lo);
    r.val = r.sat ? acc : ((b ? acc + ACC_W'(1) : (bipolar ? acc - ACC_W'(1) : acc)) & mask);
    return r;
  endfunction
endpackage

// File: rtl/stoch_chan_acc.sv
// stoch_chan_acc: one channel's N-bit saturating accumulator with sticky clamp flag.
module stoch_chan_acc
  import stoch_pkg::*;
#(
  parameter int N = 14,
  parameter int BIPOLAR = MODE_UNIPOLAR
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [N-1:0] o_nxt_acc,
  output logic         o_nxt_sat
);
  logic [N-1:0] r_acc;
  logic r_sat;
  sat_res_t w_res;
  logic [ACC_W-N-1:0] w_hi_unused;
  assign w_res = sat_add(ACC_W'(r_acc), i_bit, BIPOLAR != MODE_UNIPOLAR, N);
  assign {w_hi_unused, o_nxt_acc} = w_res.val;
  assign o_nxt_sat = r_sat | w_res.sat;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (i_en) begin
      r_acc <= o_nxt_acc;
      r_sat <= o_nxt_sat;
    end
  end
endmodule

// File: rtl/stoch_window_counter.sv
// stoch_window_counter: multi-channel windowed stochastic-to-binary converter.
// Counts BIT_IN over 2^WIN_LOG2 enabled cycles and publishes per-channel results with a VALID strobe.
module stoch_window_counter
  import stoch_pkg::*;
#(
  parameter int N = 14,
  parameter int CH = 4,
  parameter int WIN_LOG2 = 8,
  parameter int BIPOLAR = MODE_UNIPOLAR,
  parameter int CONT = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_en,
  input  logic [CH-1:0]   i_bit_in,
  output logic [CH*N-1:0] o_count_out,
  output logic            o_valid,
  output logic            o_busy,
  output logic [CH-1:0]   o_sat
);
  state_t r_state, w_state_nxt;
  logic [WIN_LOG2-1:0] r_win;
  logic [CH*N-1:0] r_count, w_acc_nxt;
  logic [CH-1:0] r_sat, w_sat_nxt;
  logic r_valid, w_run, w_step, w_done, w_clr;
  assign w_run = r_state == ST_RUN;
  assign w_step = w_run && i_en;
  assign w_done = w_step && (&r_win);
  // START outside completion aborts; on completion it only chains the next window.
  assign w_clr = i_start || w_done;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (i_start || (w_done && CONT != 0)) ? ST_RUN : (w_done ? ST_IDLE : r_state);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_win   <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
      r_sat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_clr ? '0 : r_win + WIN_LOG2'(w_step);
      r_valid <= w_done;
      if (w_done) begin
        r_count <= w_acc_nxt;
        r_sat   <= w_sat_nxt;
      end
    end
  end
  for (genvar g = 0; g < CH; g++) begin : g_ch
    stoch_chan_acc #(.N(N), .BIPOLAR(BIPOLAR)) u_acc (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clr    (w_clr),
      .i_en     (w_step),
      .i_bit    (i_bit_in[g]),
      .o_nxt_acc(w_acc_nxt[g*N +: N]),
      .o_nxt_sat(w_sat_nxt[g])
    );
  end
  assign o_count_out = r_count;
  assign o_valid = r_valid;
  assign o_busy = w_run;
  assign o_sat = r_sat;
endmodule

// File: tb/tb_stoch_window_counter.sv
// tb_stoch_window_counter: several configurations driven in lockstep, each checked every cycle
// against a counting model, plus literal expectations for the directed windows.
module tb_stoch_window_counter;
  localparam int NG = 6;
  localparam int NT[NG] = '{4, 4, 3, 4, 14, 3};
  localparam int CT[NG] = '{2, 2, 2, 2, 4, 2};
  localparam int WT[NG] = '{3, 3, 3, 3, 8, 3};
  localparam int BT[NG] = '{0, 1, 0, 0, 0, 1};
  localparam int KT[NG] = '{0, 0, 0, 1, 0, 0};
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, en = 1'b0;
  logic [3:0] bits = '0;
  int cyc = 0, errors = 0, checks = 0;
  wire [63:0] act_cnt[NG], exp_cnt[NG];
  wire [3:0] act_sat[NG], exp_sat[NG];
  wire act_valid[NG], exp_valid[NG], act_busy[NG], exp_busy[NG];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NG; g++) begin : gi
    localparam int NN = NT[g], CC = CT[g], WW = WT[g], BB = BT[g], KK = KT[g];
    localparam int HI = BB != 0 ? (1 << (NN - 1)) - 1 : (1 << NN) - 1;
    localparam int LO = BB != 0 ? -(1 << (NN - 1)) : 0;
    wire [CC*NN-1:0] cnt;
    wire [CC-1:0] s;
    wire v, b;
    stoch_window_counter #(.N(NN), .CH(CC), .WIN_LOG2(WW), .BIPOLAR(BB), .CONT(KK)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_en(en), .i_bit_in(bits[CC-1:0]),
      .o_count_out(cnt), .o_valid(v), .o_busy(b), .o_sat(s));
    int acc[CC] = '{default: 0};
    int k = 0;
    logic run = 1'b0, ev = 1'b0, done = 1'b0;
    logic [CC-1:0] ms = '0, es = '0;
    logic [CC*NN-1:0] ec = '0;
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        run = 1'b0; k = 0; ev = 1'b0; ec = '0; es = '0; ms = '0;
        foreach (acc[c]) acc[c] = 0;
      end else begin
        done = run && en && k == (1 << WW) - 1;
        ev = done;
        if (run && en && (done || !start)) begin
          for (int c = 0; c < CC; c++) begin
            acc[c] = acc[c] + (bits[c] ? 1 : -BB);
            if (acc[c] > HI) begin acc[c] = HI; ms[c] = 1'b1; end
            if (acc[c] < LO) begin acc[c] = LO; ms[c] = 1'b1; end
          end
          k++;
        end
        if (done) begin
          for (int c = 0; c < CC; c++) ec[c*NN +: NN] = NN'(acc[c]);
          es = ms;
        end
        if (done || start) begin
          foreach (acc[c]) acc[c] = 0;
          ms = '0;
          k = 0;
        end
        run = done ? (KK != 0 || start) : (run || start);
      end
    end
    assign act_cnt[g] = 64'(cnt);
    assign exp_cnt[g] = 64'(ec);
    assign act_sat[g] = 4'(s);
    assign exp_sat[g] = 4'(es);
    assign act_valid[g] = v;
    assign exp_valid[g] = ev;
    assign act_busy[g] = b;
    assign exp_busy[g] = run;
  end

  task automatic chk(input string nm, input int g, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h", nm, g, cyc, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int g = 0; g < NG; g++) begin
      chk("valid", g, 64'(act_valid[g]), 64'(exp_valid[g]));
      chk("busy", g, 64'(act_busy[g]), 64'(exp_busy[g]));
      chk("count", g, act_cnt[g], exp_cnt[g]);
      chk("sat", g, 64'(act_sat[g]), 64'(exp_sat[g]));
    end
  end

  task automatic wait_valid(input int g, input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (act_valid[g]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_valid inst%0d timeout got=none want=valid", g);
    end
  endtask

  task automatic window(input logic [7:0] p0, input logic [7:0] p1, input int gap_at,
                        input int gap_len, output int t0);
    start = 1'b1; en = 1'b0; bits = 4'($urandom);
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) begin
        en = 1'b0;
        repeat (gap_len) begin bits = 4'($urandom); @(negedge clk); end
      end
      en = 1'b1;
      bits = {2'($urandom), p1[7-i], p0[7-i]};
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  initial begin
    int t0, t1, t2, t3, dens, sp;
    logic seen;
    @(negedge clk);
    chk("rst_cnt", 4, act_cnt[4], 64'h0);
    chk("rst_busy", 4, 64'(act_busy[4]), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    window(8'b10110101, 8'hFF, -1, 0, t0);
    chk("s2_valid", 0, 64'(act_valid[0]), 64'h1);
    chk("s2_lat", 0, 64'(cyc - t0), 64'd8);
    chk("s2_cnt", 0, act_cnt[0], 64'h85);
    chk("s2_sat", 0, 64'(act_sat[0]), 64'h0);
    window(8'b10110101, 8'hFF, 4, 3, t0);
    chk("s3_valid", 0, 64'(act_valid[0]), 64'h1);
    chk("s3_lat", 0, 64'(cyc - t0), 64'd11);
    chk("s3_cnt", 0, act_cnt[0], 64'h85);
    window(8'h00, 8'b11000000, -1, 0, t0);
    chk("s4_cnt", 1, act_cnt[1], 64'hC8);
    chk("s4_sat", 1, 64'(act_sat[1]), 64'h0);
    chk("s4_bsat_cnt", 5, act_cnt[5], 64'h24);
    chk("s4_bsat_sat", 5, 64'(act_sat[5]), 64'h1);
    window(8'hFF, 8'h00, -1, 0, t0);
    chk("s5_cnt", 2, act_cnt[2], 64'h07);
    chk("s5_sat", 2, 64'(act_sat[2]), 64'h1);
    window(8'h00, 8'h00, -1, 0, t0);
    chk("s5b_cnt", 2, act_cnt[2], 64'h0);
    chk("s5b_sat", 2, 64'(act_sat[2]), 64'h0);
    start = 1'b1; en = 1'b0;
    @(negedge clk);
    start = 1'b0; en = 1'b1; bits = 4'($urandom);
    t0 = cyc;
    wait_valid(3, 20, t1);
    chk("s6_first", 3, 64'(t1 - t0), 64'd8);
    wait_valid(3, 20, t2);
    chk("s6_b2b", 3, 64'(t2 - t1), 64'd8);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    wait_valid(3, 20, t3);
    chk("s6_restart", 3, 64'(t3 - t0), 64'd8);
    for (int ph = 0; ph < 8; ph++) begin
      dens = $urandom_range(0, 16);
      sp = ph[0] ? 12 : 1500;
      repeat (400) begin
        start = ($urandom % sp) == 0;
        en = ($urandom % 4) != 0;
        for (int c = 0; c < 4; c++) bits[c] = $urandom_range(0, 15) < dens;
        @(negedge clk);
      end
    end
    start = 1'b1; en = 1'b0;
    @(negedge clk);
    start = 1'b0; en = 1'b1;
    repeat (256) begin bits = 4'($urandom); @(negedge clk); end
    chk("full_valid", 4, 64'(act_valid[4]), 64'h1);
    start = 1'b1; bits = 4'hF;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("s1_busy_pre", 4, 64'(act_busy[4]), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("s1_busy", 4, 64'(act_busy[4]), 64'h0);
    chk("s1_cnt", 4, act_cnt[4], 64'h0);
    chk("s1_sat", 4, 64'(act_sat[4]), 64'h0);
    chk("s1_valid", 4, 64'(act_valid[4]), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (act_valid[4]) seen = 1'b1;
    end
    chk("s1_novalid", 4, 64'(seen), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
